// File: rtl/serial_link_pkg.sv
// Shared types and framing helpers for the serial link transmitter.
package serial_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_GAP
    } state_e;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;

    function automatic int unsigned beats(input int unsigned data_w, input int unsigned lanes);
        return (data_w + lanes - 1) / lanes;
    endfunction

    function automatic int unsigned frame_len(input int unsigned data_w, input int unsigned lanes,
                                              input int unsigned parity_en, input int unsigned gap);
        return 1 + beats(data_w, lanes) + parity_en + gap;
    endfunction

endpackage

// File: rtl/serial_link_tx_if.sv
// Ready/valid word handshake from the router core into the transmitter.
interface serial_link_tx_if #(
    parameter int unsigned DATA_W = 55
) ();
    logic [DATA_W-1:0] TX_Data;
    logic              TX_Data_Valid;
    logic              TX_Data_Ready;

    modport master (output TX_Data, output TX_Data_Valid, input  TX_Data_Ready);
    modport slave  (input  TX_Data, input  TX_Data_Valid, output TX_Data_Ready);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/serial_link_tx.sv
// Multi-lane framed serial transmitter: start beat, LSB-first data beats, optional
// even-parity beat and idle gap, fed from an input FIFO.
module serial_link_tx
    import serial_link_pkg::*;
#(
    parameter int unsigned DATA_W    = 55,
    parameter int unsigned LANES     = 1,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned GAP       = 1,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic             Clk_S,
    input  logic             Rst,
    serial_link_tx_if.slave  tx,
    output logic [LANES-1:0] S_Data_out,
    output logic             Busy,
    output logic             Frame_Done
);
    localparam int unsigned BEATS   = beats(DATA_W, LANES);
    localparam int unsigned SH_W    = BEATS * LANES;
    localparam int unsigned BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned GAP_CW  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    state_e             state, state_nxt;
    logic [BEAT_CW-1:0] beat_cnt, beat_nxt;
    logic [GAP_CW-1:0]  gap_cnt, gap_nxt;
    logic [SH_W-1:0]    shreg, shreg_nxt;
    logic [LANES-1:0]   par, par_nxt;
    logic [LANES-1:0]   out_nxt;
    logic               done_nxt;
    logic               pop_c;
    logic               frame_end;

    logic [DATA_W-1:0]  fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    assign tx.TX_Data_Ready = ~fifo_full;
    assign Busy             = (state != ST_IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk_S),
        .rst   (Rst),
        .push  (tx.TX_Data_Valid & ~fifo_full),
        .pop   (pop_c),
        .wdata (tx.TX_Data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge Clk_S) begin
        if (Rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            par        <= '0;
            S_Data_out <= {LANES{LINE_IDLE}};
            Frame_Done <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_nxt;
            gap_cnt    <= gap_nxt;
            shreg      <= shreg_nxt;
            par        <= par_nxt;
            S_Data_out <= out_nxt;
            Frame_Done <= done_nxt;
        end
    end

    // The line register shows, one edge later, the beat that the current state describes.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        gap_nxt   = gap_cnt;
        shreg_nxt = shreg;
        par_nxt   = par;
        out_nxt   = {LANES{LINE_IDLE}};
        done_nxt  = 1'b0;
        pop_c     = 1'b0;
        frame_end = 1'b0;

        case (state)
            ST_IDLE: pop_c = ~fifo_empty;
            ST_START: begin
                out_nxt   = {LANES{LINE_START}};
                beat_nxt  = '0;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                out_nxt   = shreg[LANES-1:0];
                par_nxt   = par ^ shreg[LANES-1:0];
                shreg_nxt = shreg >> LANES;
                beat_nxt  = beat_cnt + 1'b1;
                if (beat_cnt == BEAT_CW'(BEATS - 1)) begin
                    if (PARITY_EN != 0) begin
                        state_nxt = ST_PARITY;
                    end else if (GAP > 0) begin
                        gap_nxt   = '0;
                        state_nxt = ST_GAP;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                out_nxt = par;
                if (GAP > 0) begin
                    gap_nxt   = '0;
                    state_nxt = ST_GAP;
                end else begin
                    frame_end = 1'b1;
                end
            end
            ST_GAP: begin
                gap_nxt = gap_cnt + 1'b1;
                if (gap_cnt == GAP_CW'(GAP - 1)) frame_end = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // End of frame chains straight into the next start beat when a word is waiting.
        if (frame_end) begin
            done_nxt = 1'b1;
            pop_c    = ~fifo_empty;
        end
        if (pop_c) begin
            shreg_nxt = SH_W'(fifo_rdata);
            par_nxt   = '0;
            state_nxt = ST_START;
        end else if (frame_end) begin
            state_nxt = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_serial_link_tx.sv
// Bench for serial_link_tx across four parameter sets against a frame-timeline model.
module tb_serial_link_tx;

    localparam int MAXC = 8192;
    localparam int DEP  = 4;

    int unsigned cw [4] = '{8, 55, 4, 8};
    int unsigned cl [4] = '{1, 2, 1, 8};
    int unsigned cg [4] = '{1, 1, 0, 2};
    int unsigned cp [4] = '{1, 1, 0, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        drv_valid = 1'b0;
    logic [63:0] drv_data = '0;
    int          sel = 0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    logic [0:0] so0, so2;
    logic [1:0] so1;
    logic [7:0] so3;
    logic       b0, b1, b2, b3, fd0, fd1, fd2, fd3;

    serial_link_tx_if #(.DATA_W(8))  if0 ();
    serial_link_tx_if #(.DATA_W(55)) if1 ();
    serial_link_tx_if #(.DATA_W(4))  if2 ();
    serial_link_tx_if #(.DATA_W(8))  if3 ();

    assign if0.TX_Data_Valid = drv_valid && (sel == 0);
    assign if1.TX_Data_Valid = drv_valid && (sel == 1);
    assign if2.TX_Data_Valid = drv_valid && (sel == 2);
    assign if3.TX_Data_Valid = drv_valid && (sel == 3);
    assign if0.TX_Data = drv_data[7:0];
    assign if1.TX_Data = drv_data[54:0];
    assign if2.TX_Data = drv_data[3:0];
    assign if3.TX_Data = drv_data[7:0];

    serial_link_tx #(.DATA_W(8), .LANES(1), .DEPTH(4), .GAP(1), .PARITY_EN(1)) dut0 (
        .Clk_S(clk), .Rst(rst), .tx(if0), .S_Data_out(so0), .Busy(b0), .Frame_Done(fd0));
    serial_link_tx #(.DATA_W(55), .LANES(2), .DEPTH(4), .GAP(1), .PARITY_EN(1)) dut1 (
        .Clk_S(clk), .Rst(rst), .tx(if1), .S_Data_out(so1), .Busy(b1), .Frame_Done(fd1));
    serial_link_tx #(.DATA_W(4), .LANES(1), .DEPTH(4), .GAP(0), .PARITY_EN(0)) dut2 (
        .Clk_S(clk), .Rst(rst), .tx(if2), .S_Data_out(so2), .Busy(b2), .Frame_Done(fd2));
    serial_link_tx #(.DATA_W(8), .LANES(8), .DEPTH(4), .GAP(2), .PARITY_EN(1)) dut3 (
        .Clk_S(clk), .Rst(rst), .tx(if3), .S_Data_out(so3), .Busy(b3), .Frame_Done(fd3));

    // Observed {ready, busy, done, lanes} of the selected DUT
    logic [10:0] obs;
    always_comb begin
        case (sel)
            0:       obs = {if0.TX_Data_Ready, b0, fd0, 7'b0, so0};
            1:       obs = {if1.TX_Data_Ready, b1, fd1, 6'b0, so1};
            2:       obs = {if2.TX_Data_Ready, b2, fd2, 7'b0, so2};
            3:       obs = {if3.TX_Data_Ready, b3, fd3, so3};
            default: obs = '0;
        endcase
    end

    // Model: each accepted word owns a frame starting at max(accept+2, previous end+1)
    bit [7:0] exp_out  [MAXC];
    bit       exp_done [MAXC];
    int       wa[$], ws[$], we[$];
    int       last_end = -10;

    function automatic void model_reset(input int r);
        wa.delete(); ws.delete(); we.delete();
        last_end = -10;
        for (int i = r; i < MAXC; i++) begin
            exp_out[i]  = '0;
            exp_done[i] = 1'b0;
        end
    endfunction

    function automatic void model_accept(input int a, input logic [63:0] d);
        int w, l, b, fl, s, idx;
        bit [7:0] v, p;
        w = int'(cw[sel]); l = int'(cl[sel]);
        b = (w + l - 1) / l;
        fl = 1 + b + int'(cp[sel]) + int'(cg[sel]);
        s = a + 2;
        if (last_end + 1 > s) s = last_end + 1;
        if (s + fl >= MAXC) return;
        exp_out[s] = 8'((1 << l) - 1);
        p = '0;
        for (int j = 0; j < b; j++) begin
            v = '0;
            for (int k = 0; k < l; k++) begin
                idx = j * l + k;
                if (idx < w) v[k] = d[idx];
            end
            exp_out[s + 1 + j] = v;
            p = p ^ v;
        end
        if (cp[sel] != 0) exp_out[s + 1 + b] = p;
        exp_done[s + fl - 1] = 1'b1;
        wa.push_back(a); ws.push_back(s); we.push_back(s + fl - 1);
        last_end = s + fl - 1;
    endfunction

    function automatic int cnt_after(input int t);
        int n;
        n = 0;
        foreach (wa[i]) if (wa[i] <= t && ws[i] - 1 > t) n++;
        return n;
    endfunction

    function automatic logic [10:0] exp_vec(input int t);
        logic bz;
        bz = 1'b0;
        foreach (wa[i]) if (wa[i] <= t && t < we[i]) bz = 1'b1;
        return {cnt_after(t) < DEP, bz, exp_done[t], exp_out[t]};
    endfunction

    task automatic cycle(input logic v, input logic [63:0] d, output logic acc);
        int t;
        t = cyc + 1;
        acc = v && (cnt_after(t - 1) < DEP);
        drv_valid = v;
        drv_data  = d;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        drv_valid = 1'b0;
        if (acc) model_accept(t, d);
    endtask

    task automatic cycle_rst();
        rst = 1'b1;
        drv_valid = 1'b0;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        rst = 1'b0;
        model_reset(cyc);
    endtask

    task automatic test_reset();
        cycle_rst();
        cycle_rst();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            n_chk++;
            if (obs !== 11'h400) $display("FAIL reset sel=%0d got=%h exp=%h", s, obs, 11'h400);
            else n_pass++;
        end
        sel = 0;
    endtask

    task automatic test_single_frame();
        logic acc;
        logic [10:0] ev;
        logic [11:0] cap, dn;
        int a;
        sel = 0; model_reset(cyc + 1);
        cycle(1'b1, 64'hA5, acc);
        a = cyc;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, '0, acc);
            ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) $display("FAIL single_frame cyc=%0d got=%h exp=%h", cyc - a, obs, ev);
            else n_pass++;
            cap[i] = obs[0];
            dn[i]  = obs[8];
        end
        n_chk++;
        if (cap !== 12'h296) $display("FAIL single_frame_stream got=%h exp=%h", cap, 12'h296);
        else n_pass++;
        n_chk++;
        if (dn !== 12'h800) $display("FAIL single_frame_done got=%h exp=%h", dn, 12'h800);
        else n_pass++;
    endtask

    task automatic test_two_lanes();
        logic acc;
        logic [10:0] ev;
        logic [1:0] b27, bp;
        int a;
        sel = 1; model_reset(cyc + 1);
        cycle(1'b1, 64'h007F_FFFF_FFFF_FFFF, acc);
        a = cyc;
        b27 = 'x; bp = 'x;
        while (cyc < a + 32) begin
            cycle(1'b0, '0, acc);
            ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) $display("FAIL two_lanes cyc=%0d got=%h exp=%h", cyc - a, obs, ev);
            else n_pass++;
            if (cyc == a + 30) b27 = obs[1:0];
            if (cyc == a + 31) bp  = obs[1:0];
        end
        n_chk++;
        if (b27 !== 2'b01) $display("FAIL two_lanes_pad got=%b exp=%b", b27, 2'b01);
        else n_pass++;
        n_chk++;
        if (bp !== 2'b10) $display("FAIL two_lanes_parity got=%b exp=%b", bp, 2'b10);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic [10:0] ev;
        logic [9:0] cap;
        int a, nd;
        sel = 2; model_reset(cyc + 1);
        cap = '0; nd = 0;
        cycle(1'b1, 64'h3, acc);
        a = cyc;
        cycle(1'b1, 64'hC, acc);
        while (cyc < a + 12) begin
            if (cyc >= a + 2) cap[cyc - a - 2] = obs[0];
            if (obs[8] === 1'b1) nd++;
            cycle(1'b0, '0, acc);
            ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc - a, obs, ev);
            else n_pass++;
        end
        n_chk++;
        if (cap !== 10'h327) $display("FAIL back_to_back_stream got=%h exp=%h", cap, 10'h327);
        else n_pass++;
        n_chk++;
        if (nd !== 2) $display("FAIL back_to_back_done got=%0d exp=2", nd);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic acc, saw_low;
        logic [10:0] ev;
        logic [63:0] d;
        int n_acc, nd, guard;
        sel = 0; model_reset(cyc + 1);
        n_acc = 0; nd = 0; saw_low = 1'b0; guard = 0;
        d = 64'($urandom_range(0, 255));
        while (n_acc < 6 && guard < 60) begin
            cycle(1'b1, d, acc);
            guard++;
            if (acc) begin
                n_acc++;
                d = 64'($urandom_range(0, 255));
            end
            ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) $display("FAIL fifo_full cyc=%0d got=%h exp=%h", cyc, obs, ev);
            else n_pass++;
            if (obs[10] === 1'b0) saw_low = 1'b1;
            if (obs[8] === 1'b1) nd++;
        end
        while (cyc <= last_end + 1) begin
            cycle(1'b0, '0, acc);
            ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) $display("FAIL fifo_full_drain cyc=%0d got=%h exp=%h", cyc, obs, ev);
            else n_pass++;
            if (obs[8] === 1'b1) nd++;
        end
        n_chk++;
        if (saw_low !== 1'b1) $display("FAIL fifo_full_ready_low got=%b exp=1", saw_low);
        else n_pass++;
        n_chk++;
        if (nd !== 6) $display("FAIL fifo_full_done_count got=%0d exp=6", nd);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic acc;
        logic [10:0] ev;
        int s0;
        sel = 0; model_reset(cyc + 1);
        cycle(1'b1, 64'h5A, acc);
        s0 = ws[0];
        cycle(1'b1, 64'hC3, acc);
        cycle(1'b1, 64'h0F, acc);
        while (cyc < s0 + 4) begin
            cycle(1'b0, '0, acc);
            ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, obs, ev);
            else n_pass++;
        end
        cycle_rst();
        n_chk++;
        if (obs !== 11'h400) $display("FAIL reset_mid_after got=%h exp=%h", obs, 11'h400);
        else n_pass++;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, '0, acc);
            ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) $display("FAIL reset_mid_quiet cyc=%0d got=%h exp=%h", cyc, obs, ev);
            else n_pass++;
        end
        cycle(1'b1, 64'h96, acc);
        while (cyc <= last_end + 1) begin
            cycle(1'b0, '0, acc);
            ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) $display("FAIL reset_mid_resume cyc=%0d got=%h exp=%h", cyc, obs, ev);
            else n_pass++;
        end
    endtask

    task automatic test_wide_lanes();
        logic acc;
        logic [10:0] ev;
        logic [39:0] cap;
        int a, dc;
        sel = 3; model_reset(cyc + 1);
        cap = '0; dc = -1;
        cycle(1'b1, 64'h81, acc);
        a = cyc;
        while (cyc < a + 8) begin
            cycle(1'b0, '0, acc);
            ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) $display("FAIL wide_lanes cyc=%0d got=%h exp=%h", cyc - a, obs, ev);
            else n_pass++;
            if (cyc >= a + 2 && cyc <= a + 6) cap = {cap[31:0], obs[7:0]};
            if (obs[8] === 1'b1) dc = cyc - a;
        end
        n_chk++;
        if (cap !== 40'hFF81810000) $display("FAIL wide_lanes_beats got=%h exp=%h", cap, 40'hFF81810000);
        else n_pass++;
        n_chk++;
        if (dc !== 6) $display("FAIL wide_lanes_done_at got=%0d exp=6", dc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic acc, v;
        logic [10:0] ev;
        logic [63:0] d;
        for (int c = 0; c < 4; c++) begin
            sel = c; model_reset(cyc + 1);
            for (int i = 0; i < 120; i++) begin
                v = ($urandom_range(0, 2) != 0);
                d = {32'($urandom), 32'($urandom)};
                cycle(v, d, acc);
                ev = exp_vec(cyc); n_chk++;
                if (obs !== ev) $display("FAIL random cfg=%0d cyc=%0d got=%h exp=%h", c, cyc, obs, ev);
                else n_pass++;
            end
            while (cyc <= last_end + 1) begin
                cycle(1'b0, '0, acc);
                ev = exp_vec(cyc); n_chk++;
                if (obs !== ev) $display("FAIL random_drain cfg=%0d cyc=%0d got=%h exp=%h", c, cyc, obs, ev);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_two_lanes();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_frame();
        test_wide_lanes();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
